// File: rtl/cordic_arbiter.sv
// cordic_arbiter
//   Round-robin scheduler sharing one pipelined CORDIC datapath between
//   NUM_REQ requesters. Accepts at most one operation per cycle, registers it
//   onto the CORDIC inputs, tracks ownership of every in-flight operation with
//   a tag shift register aligned to the datapath, and strobes each result back
//   to its owner. Per-requester credit counters bound outstanding work; idle
//   reports when every credit has been returned.
//
// Ports
//   clk                     rising-edge clock
//   reset                   asynchronous, active-low reset
//   hold                    blocks new grants; in-flight work still completes
//   req_valid[NUM_REQ]      request valid per requester
//   req_ready[NUM_REQ]      combinational grant, at most one bit high
//   req_m, req_rot_vec      mode / rotation-vectoring select per requester
//   req_x, req_y, req_z     operands, requester r at [r*N +: N]
//   cdc_m, cdc_rot_vec      registered controls to the CORDIC
//   cdc_x, cdc_y, cdc_z     registered operands to the CORDIC
//   cdc_xout/yout/zout      CORDIC results, PIPE_LAT cycles after cdc_*
//   rsp_valid[NUM_REQ]      one-hot single-cycle result strobe
//   rsp_x, rsp_y, rsp_z     registered result shared by all requesters
//   idle                    no credit outstanding anywhere
module cordic_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned N            = 16,
  parameter int unsigned PIPE_LAT     = 8,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_m,
  input  logic [NUM_REQ-1:0]   req_rot_vec,
  input  logic [NUM_REQ*N-1:0] req_x,
  input  logic [NUM_REQ*N-1:0] req_y,
  input  logic [NUM_REQ*N-1:0] req_z,
  output logic                 cdc_m,
  output logic                 cdc_rot_vec,
  output logic [N-1:0]         cdc_x,
  output logic [N-1:0]         cdc_y,
  output logic [N-1:0]         cdc_z,
  input  logic [N-1:0]         cdc_xout,
  input  logic [N-1:0]         cdc_yout,
  input  logic [N-1:0]         cdc_zout,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [N-1:0]         rsp_x,
  output logic [N-1:0]         rsp_y,
  output logic [N-1:0]         rsp_z,
  output logic                 idle
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);

  // Arbitration state
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] elig;
  logic               gnt_any;
  logic [PW-1:0]      gnt_id;

  // Issue register (drives the CORDIC inputs)
  logic               iv_q;
  logic [PW-1:0]      it_q;
  logic               cdc_m_q, cdc_rot_vec_q;
  logic [N-1:0]       cdc_x_q, cdc_y_q, cdc_z_q;

  // Tag pipe, stage k aligned with CORDIC pipeline flop k
  logic [PIPE_LAT-1:0] tv_q;
  logic [PW-1:0]       tid_q [PIPE_LAT];

  // Response register
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [N-1:0]       rsp_x_q, rsp_y_q, rsp_z_q;

  // Credits
  logic [CW-1:0]      cnt_q [NUM_REQ];
  logic [CW-1:0]      cnt_d [NUM_REQ];

  // ---------------------------------------------------------------------------
  // Eligibility and round-robin search
  // ---------------------------------------------------------------------------
  always_comb begin
    elig = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      elig[r] = req_valid[r] & ~hold & reset & (cnt_q[r] < CMAX);
    end
  end

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = PW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req_ready[r] = gnt_any && (gnt_id == PW'(r));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_id == PW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue register: a grant implies a transfer since ready is gated by valid
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iv_q          <= 1'b0;
      it_q          <= '0;
      cdc_m_q       <= 1'b0;
      cdc_rot_vec_q <= 1'b0;
      cdc_x_q       <= '0;
      cdc_y_q       <= '0;
      cdc_z_q       <= '0;
    end else begin
      iv_q <= gnt_any;
      it_q <= gnt_id;
      if (gnt_any) begin
        cdc_m_q       <= req_m[gnt_id];
        cdc_rot_vec_q <= req_rot_vec[gnt_id];
        cdc_x_q       <= req_x[32'(gnt_id)*N +: N];
        cdc_y_q       <= req_y[32'(gnt_id)*N +: N];
        cdc_z_q       <= req_z[32'(gnt_id)*N +: N];
      end
    end
  end

  assign cdc_m       = cdc_m_q;
  assign cdc_rot_vec = cdc_rot_vec_q;
  assign cdc_x       = cdc_x_q;
  assign cdc_y       = cdc_y_q;
  assign cdc_z       = cdc_z_q;

  // ---------------------------------------------------------------------------
  // Tag pipe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tv_q <= '0;
      for (int unsigned k = 0; k < PIPE_LAT; k++) begin
        tid_q[k] <= '0;
      end
    end else begin
      tv_q[0]  <= iv_q;
      tid_q[0] <= it_q;
      for (int unsigned k = 1; k < PIPE_LAT; k++) begin
        tv_q[k]  <= tv_q[k-1];
        tid_q[k] <= tid_q[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  always_comb begin
    rsp_valid_d = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      rsp_valid_d[r] = tv_q[PIPE_LAT-1] && (tid_q[PIPE_LAT-1] == PW'(r));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= '0;
      rsp_x_q     <= '0;
      rsp_y_q     <= '0;
      rsp_z_q     <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (tv_q[PIPE_LAT-1]) begin
        rsp_x_q <= cdc_xout;
        rsp_y_q <= cdc_yout;
        rsp_z_q <= cdc_zout;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_z     = rsp_z_q;

  // ---------------------------------------------------------------------------
  // Credits: taken on transfer, returned on the strobe cycle, so the returned
  // credit is visible to arbitration in the following cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      cnt_d[r] = cnt_q[r];
      if (req_ready[r] && !rsp_valid_q[r]) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (!req_ready[r] && rsp_valid_q[r]) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_comb begin
    idle = 1'b1;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (cnt_q[r] != '0) idle = 1'b0;
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
module tb_cordic_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int N            = 16;
  localparam int PIPE_LAT     = 8;
  localparam int MAX_INFLIGHT = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 hold;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   req_m;
  logic [NUM_REQ-1:0]   req_rot_vec;
  logic [NUM_REQ*N-1:0] req_x, req_y, req_z;
  logic                 cdc_m, cdc_rot_vec;
  logic [N-1:0]         cdc_x, cdc_y, cdc_z;
  logic [N-1:0]         cdc_xout, cdc_yout, cdc_zout;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [N-1:0]         rsp_x, rsp_y, rsp_z;
  logic                 idle;

  always #5 clk = ~clk;

  cordic_arbiter #(
    .NUM_REQ(NUM_REQ), .N(N), .PIPE_LAT(PIPE_LAT), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_m(req_m), .req_rot_vec(req_rot_vec),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .cdc_m(cdc_m), .cdc_rot_vec(cdc_rot_vec),
    .cdc_x(cdc_x), .cdc_y(cdc_y), .cdc_z(cdc_z),
    .cdc_xout(cdc_xout), .cdc_yout(cdc_yout), .cdc_zout(cdc_zout),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .idle(idle)
  );

  // Stand-in datapath: an arbitrary mixing of all five fields, delayed by
  // PIPE_LAT flops, so routing of every field is observable in the result.
  function automatic logic [3*N-1:0] fcordic(input logic m, input logic rv,
                                             input logic [N-1:0] x, y, z);
    logic [N-1:0] a, b, c;
    a = x + z;
    b = y ^ {N{m}};
    c = z - x + (rv ? N'(16'h1234) : N'(16'h0000));
    return {a, b, c};
  endfunction

  logic [3*N-1:0] pipe [PIPE_LAT];
  initial for (int k = 0; k < PIPE_LAT; k++) pipe[k] = '0;
  always @(posedge clk) begin
    pipe[0] <= fcordic(cdc_m, cdc_rot_vec, cdc_x, cdc_y, cdc_z);
    for (int k = 1; k < PIPE_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign {cdc_xout, cdc_yout, cdc_zout} = pipe[PIPE_LAT-1];

  // Reference model: credits, pointer, and an in-order list of outstanding
  // operations each carrying the cycle its strobe is due.
  typedef struct {
    int           id;
    logic         m, rv;
    logic [N-1:0] x, y, z;
    int           due;
  } op_t;

  op_t         q[$];
  int          m_cnt [NUM_REQ];
  int          m_ptr;
  int          m_cyc;
  logic [63:0] m_cdc, m_rsp;
  int          g_last;
  int          n_chk, n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    int          g;
    logic        strobe;
    logic [63:0] exp_ready, exp_rsp;
    logic        exp_idle;
    op_t         o;
    if (!reset) begin
      q.delete();
      for (int r = 0; r < NUM_REQ; r++) m_cnt[r] = 0;
      m_ptr = 0;
      m_cdc = '0;
      m_rsp = '0;
    end
    g = -1;
    if (reset && !hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int r;
        r = (m_ptr + i) % NUM_REQ;
        if (g < 0 && req_valid[r] && m_cnt[r] < MAX_INFLIGHT) g = r;
      end
    end
    exp_ready = (g >= 0) ? (64'(1) << g) : 64'(0);
    strobe    = (q.size() > 0) && (q[0].due == m_cyc);
    exp_rsp   = strobe ? (64'(1) << q[0].id) : 64'(0);
    if (strobe) m_rsp = 64'(fcordic(q[0].m, q[0].rv, q[0].x, q[0].y, q[0].z));
    exp_idle = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) if (m_cnt[r] != 0) exp_idle = 1'b0;

    #1;
    check("req_ready", 64'(req_ready), exp_ready);
    check("rsp_valid", 64'(rsp_valid), exp_rsp);
    check("idle", 64'(idle), 64'(exp_idle));
    check("cdc_regs", 64'({cdc_m, cdc_rot_vec, cdc_x, cdc_y, cdc_z}), m_cdc);
    check("rsp_data", 64'({rsp_x, rsp_y, rsp_z}), m_rsp);

    @(posedge clk);
    if (reset) begin
      if (g >= 0) begin
        o.id  = g;
        o.m   = req_m[g];
        o.rv  = req_rot_vec[g];
        o.x   = req_x[g*N +: N];
        o.y   = req_y[g*N +: N];
        o.z   = req_z[g*N +: N];
        o.due = m_cyc + PIPE_LAT + 2;
        q.push_back(o);
        m_cnt[g]++;
        m_ptr = (g + 1) % NUM_REQ;
        m_cdc = 64'({o.m, o.rv, o.x, o.y, o.z});
      end
      if (strobe) begin
        m_cnt[q[0].id]--;
        void'(q.pop_front());
      end
    end
    m_cyc++;
    g_last = g;
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic v, input logic m, input logic rv,
                         input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] z);
    req_valid[r]     = v;
    req_m[r]         = m;
    req_rot_vec[r]   = rv;
    req_x[r*N +: N]  = x;
    req_y[r*N +: N]  = y;
    req_z[r*N +: N]  = z;
  endtask

  task automatic set_all(input int seed);
    for (int r = 0; r < NUM_REQ; r++)
      set_req(r, 1'b1, r[0], r[1], N'(seed*64 + r*16 + 1), N'(seed*64 + r*16 + 2),
              N'(seed*64 + r*16 + 3));
  endtask

  task automatic idle_steps(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_chk = 0; n_err = 0; m_cyc = 0; m_ptr = 0; g_last = -1;
    m_cdc = '0; m_rsp = '0;
    for (int r = 0; r < NUM_REQ; r++) m_cnt[r] = 0;
    reset = 1'b1; hold = 1'b0;
    req_valid = '0; req_m = '0; req_rot_vec = '0;
    req_x = '0; req_y = '0; req_z = '0;
    #1 reset = 1'b0;
    @(negedge clk);

    // Reset with every requester valid, then release: first grant to r0,
    // then continuous round-robin.
    set_all(1);
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) step();
    idle_steps(14);

    // Credit limit: requester 1 alone.
    set_req(1, 1'b1, 1'b1, 1'b0, 16'h1111, 16'h2222, 16'h3333);
    for (int i = 0; i < 16; i++) step();
    idle_steps(14);

    // Single operation from requester 2.
    set_req(2, 1'b1, 1'b0, 1'b0, 16'h4000, 16'h0000, 16'h2000);
    step();
    idle_steps(14);

    // Hold and drain.
    set_all(2);
    for (int i = 0; i < 3; i++) step();
    hold = 1'b1;
    for (int i = 0; i < 14; i++) step();
    hold = 1'b0;
    for (int i = 0; i < 6; i++) step();
    idle_steps(14);

    // Reset with five operations in flight.
    set_all(3);
    for (int i = 0; i < 5; i++) step();
    req_valid = '0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle_steps(14);
    set_all(4);
    for (int i = 0; i < 3; i++) step();
    idle_steps(14);

    // Randomized traffic with holds, withdrawals and occasional resets.
    for (int c = 0; c < 700; c++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req_valid[r] && g_last != r) begin
          if ($urandom_range(7) == 0) req_valid[r] = 1'b0;
        end else if ($urandom_range(1) == 0) begin
          set_req(r, 1'b1, 1'($urandom), 1'($urandom), N'($urandom), N'($urandom),
                  N'($urandom));
        end else begin
          req_valid[r] = 1'b0;
        end
      end
      if ($urandom_range(15) == 0) hold = ~hold;
      reset = ($urandom_range(199) != 0);
      step();
    end
    reset = 1'b1;
    hold  = 1'b0;
    idle_steps(16);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
